// File: rtl/battle_pkg.sv
// Shared definitions for the battle hit-point controller.
// Holds the FSM state encoding, the hit-point width and the default
// values of the controller parameters.
package battle_pkg;

  localparam int HP_W = 4;

  localparam int unsigned HP_INIT_DEF       = 9;
  localparam int unsigned HIT_THRESHOLD_DEF = 7;
  localparam int unsigned DAMAGE_DEF        = 1;
  localparam int unsigned TIMEOUT_DEF       = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RND = 2'd1,
    ST_APPLY    = 2'd2,
    ST_OVER     = 2'd3
  } state_e;

endpackage

// File: rtl/hp_counter.sv
// Hit-point register with load, saturating subtract and zero flag.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset (loads HP_INIT)
//   load_i        restore HP_INIT on the next edge (wins over dec_i)
//   dec_i         subtract DAMAGE on the next edge, saturating at 0
//   hp_o          current hit points (registered)
//   zero_next_o   the value hp_o will take on the next edge is zero
module hp_counter
  import battle_pkg::*;
#(
  parameter int unsigned HP_INIT = HP_INIT_DEF,
  parameter int unsigned DAMAGE  = DAMAGE_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            dec_i,
  output logic [HP_W-1:0] hp_o,
  output logic            zero_next_o
);

  localparam logic [HP_W-1:0] INIT_V = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0] DMG_V  = HP_W'(DAMAGE);

  logic [HP_W-1:0] hp_q, hp_d;

  always_comb begin
    hp_d = hp_q;
    if (load_i) begin
      hp_d = INIT_V;
    end else if (dec_i) begin
      // Saturate instead of wrapping when damage exceeds remaining hp.
      hp_d = (hp_q > DMG_V) ? (hp_q - DMG_V) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hp_q <= INIT_V;
    else         hp_q <= hp_d;
  end

  assign hp_o        = hp_q;
  assign zero_next_o = (hp_d == '0);

endmodule

// File: rtl/battle_hp_ctrl.sv
// Battle hit-point controller. An attack draws one random sample through
// a valid/ready port; samples above HIT_THRESHOLD remove DAMAGE hit points.
// Ports:
//   clk, reset (async, active-low)
//   attack, new_game            single-cycle requests
//   rnd_valid, rnd_data         random source sample
//   rnd_ready                   sample accepted this cycle (WAIT_RND only)
//   hp, hit, miss, game_over    game status (registered)
//   rnd_fault                   sticky: last wait for a sample timed out
//   draw_count                  accepted samples since reset/new_game
//   dbg_state                   current FSM state
//
// Handshake: a sample transfers on a rising edge where rnd_valid and
// rnd_ready are both 1. rnd_ready depends only on the state register, so a
// source may hold rnd_valid indefinitely; samples offered while rnd_ready is
// 0 are neither consumed nor counted. A transfer coinciding with new_game is
// still a transfer from the source's point of view, but it is discarded.
module battle_hp_ctrl
  import battle_pkg::*;
#(
  parameter int unsigned HP_INIT       = HP_INIT_DEF,
  parameter int unsigned HIT_THRESHOLD = HIT_THRESHOLD_DEF,
  parameter int unsigned DAMAGE        = DAMAGE_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            attack,
  input  logic            new_game,
  input  logic            rnd_valid,
  input  logic [3:0]      rnd_data,
  output logic            rnd_ready,
  output logic [HP_W-1:0] hp,
  output logic            hit,
  output logic            miss,
  output logic            game_over,
  output logic            rnd_fault,
  output logic [7:0]      draw_count,
  output state_e          dbg_state
);

  localparam logic [3:0] THR_V = 4'(HIT_THRESHOLD);
  localparam logic [7:0] TMO_V = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] sample_q, sample_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       over_q, over_d;
  logic       fault_q, fault_d;

  logic       hp_load, hp_dec, hp_zero_next;
  logic       xfer;
  logic       is_hit;

  assign xfer   = rnd_valid && (state_q == ST_WAIT_RND);
  assign is_hit = (sample_q > THR_V);

  hp_counter #(
    .HP_INIT (HP_INIT),
    .DAMAGE  (DAMAGE)
  ) u_hp (
    .clk_i       (clk),
    .rst_ni      (reset),
    .load_i      (hp_load),
    .dec_i       (hp_dec),
    .hp_o        (hp),
    .zero_next_o (hp_zero_next)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    over_d   = over_q;
    fault_d  = fault_q;
    hp_load  = 1'b0;
    hp_dec   = 1'b0;

    if (new_game) begin
      // Overrides everything, including a sample transferring this edge.
      state_d = ST_IDLE;
      tmo_d   = '0;
      cnt_d   = '0;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      over_d  = 1'b0;
      fault_d = 1'b0;
      hp_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (attack) begin
            state_d = ST_WAIT_RND;
            tmo_d   = '0;
            fault_d = 1'b0;
          end
        end
        ST_WAIT_RND: begin
          if (xfer) begin
            sample_d = rnd_data;
            cnt_d    = cnt_q + 8'd1;
            state_d  = ST_APPLY;
          end else begin
            tmo_d = tmo_q + 8'd1;
            if ((tmo_q + 8'd1) == TMO_V) begin
              fault_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_APPLY: begin
          hp_dec = is_hit;
          hit_d  = is_hit;
          miss_d = !is_hit;
          // Exit decision uses the post-update hp.
          if (hp_zero_next) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OVER: begin
          // Only new_game leaves this state.
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
      fault_q  <= fault_d;
    end
  end

  assign rnd_ready  = (state_q == ST_WAIT_RND);
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign game_over  = over_q;
  assign rnd_fault  = fault_q;
  assign draw_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_battle_hp_ctrl.sv
// Directed bench for battle_hp_ctrl. Two instances share all inputs: the
// default configuration (a) and one with HP_INIT=10, DAMAGE=4 (b) used to
// show saturation at zero.
module tb_battle_hp_ctrl;
  import battle_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       attack = 1'b0;
  logic       new_game = 1'b0;
  logic       rnd_valid = 1'b0;
  logic [3:0] rnd_data = '0;

  logic       rdy_a, hit_a, miss_a, go_a, flt_a;
  logic [3:0] hp_a;
  logic [7:0] cnt_a;
  state_e     st_a;

  logic       rdy_b, hit_b, miss_b, go_b, flt_b;
  logic [3:0] hp_b;
  logic [7:0] cnt_b;
  state_e     st_b;

  battle_hp_ctrl u_dut_a (
    .clk(clk), .reset(reset), .attack(attack), .new_game(new_game),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rdy_a),
    .hp(hp_a), .hit(hit_a), .miss(miss_a), .game_over(go_a),
    .rnd_fault(flt_a), .draw_count(cnt_a), .dbg_state(st_a)
  );

  battle_hp_ctrl #(.HP_INIT(10), .DAMAGE(4)) u_dut_b (
    .clk(clk), .reset(reset), .attack(attack), .new_game(new_game),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rdy_b),
    .hp(hp_b), .hit(hit_b), .miss(miss_b), .game_over(go_b),
    .rnd_fault(flt_b), .draw_count(cnt_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_new_game();
    step(); new_game = 1'b1;
    step(); new_game = 1'b0;
  endtask

  // Attack, offer one sample, return once the APPLY edge has passed.
  task automatic draw(input logic [3:0] d);
    step(); attack = 1'b1;
    step(); attack = 1'b0;
    check_eq("ready_in_wait", rdy_a, 1'b1);
    rnd_valid = 1'b1; rnd_data = d;
    step(); rnd_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, asynchronously applied before any clock edge.
    #1 reset = 1'b0;
    #2;
    check_eq("rst_hp", hp_a, 9);
    check_eq("rst_hit", hit_a, 0);
    check_eq("rst_miss", miss_a, 0);
    check_eq("rst_go", go_a, 0);
    check_eq("rst_flt", flt_a, 0);
    check_eq("rst_cnt", cnt_a, 0);
    check_eq("rst_ready", rdy_a, 0);
    check_eq("rst_state", st_a, ST_IDLE);
    step(); step();
    reset = 1'b1;

    // Hit with 8: hp changes only after the APPLY edge.
    step(); attack = 1'b1;
    step(); attack = 1'b0; rnd_valid = 1'b1; rnd_data = 4'd8;
    step(); rnd_valid = 1'b0;
    check_eq("hp_before_apply", hp_a, 9);
    check_eq("state_apply", st_a, ST_APPLY);
    step();
    check_eq("hit8_hp", hp_a, 8);
    check_eq("hit8_hit", hit_a, 1);
    check_eq("hit8_miss", miss_a, 0);
    check_eq("hit8_cnt", cnt_a, 1);

    // Miss with 7 (threshold value itself is not a hit).
    start_new_game();
    check_eq("ng_cnt", cnt_a, 0);
    check_eq("ng_hit", hit_a, 0);
    draw(4'd7);
    check_eq("miss7_hp", hp_a, 9);
    check_eq("miss7_miss", miss_a, 1);
    check_eq("miss7_hit", hit_a, 0);
    check_eq("miss7_cnt", cnt_a, 1);

    // Samples offered while idle are not consumed.
    rnd_valid = 1'b1; rnd_data = 4'd15;
    repeat (3) step();
    rnd_valid = 1'b0;
    check_eq("idle_offer_cnt", cnt_a, 1);
    check_eq("idle_offer_hp", hp_a, 9);

    // Nine hits down to game over.
    start_new_game();
    for (int i = 1; i <= 9; i++) exp_q.push_back(4'(9 - i));
    for (int i = 1; i <= 9; i++) begin
      logic [3:0] e;
      draw(4'd15);
      e = exp_q.pop_front();
      check_eq($sformatf("hp_hit%0d", i), hp_a, e);
    end
    check_eq("over_go", go_a, 1);
    check_eq("over_cnt", cnt_a, 9);
    check_eq("over_state", st_a, ST_OVER);
    step(); attack = 1'b1;
    step(); attack = 1'b0;
    check_eq("over_attack_ready", rdy_a, 0);
    check_eq("over_attack_hp", hp_a, 0);
    start_new_game();
    check_eq("ng_hp", hp_a, 9);
    check_eq("ng_go", go_a, 0);
    check_eq("ng_cnt2", cnt_a, 0);

    // Timeout: 255 cycles in WAIT_RND without a sample.
    step(); attack = 1'b1;
    step(); attack = 1'b0;
    check_eq("tmo_enter", st_a, ST_WAIT_RND);
    // Attack while waiting is dropped.
    attack = 1'b1;
    step(); attack = 1'b0;
    check_eq("wait_attack_state", st_a, ST_WAIT_RND);
    repeat (253) step();
    check_eq("tmo_still_wait", st_a, ST_WAIT_RND);
    check_eq("tmo_no_fault_yet", flt_a, 0);
    step();
    check_eq("tmo_state", st_a, ST_IDLE);
    check_eq("tmo_fault", flt_a, 1);
    check_eq("tmo_hp", hp_a, 9);
    check_eq("tmo_cnt", cnt_a, 0);
    step(); attack = 1'b1;
    step(); attack = 1'b0;
    check_eq("tmo_cleared", flt_a, 0);
    rnd_valid = 1'b1; rnd_data = 4'd2;
    step(); rnd_valid = 1'b0;
    step();
    check_eq("tmo_after_miss", miss_a, 1);
    check_eq("tmo_after_cnt", cnt_a, 1);

    // new_game coinciding with a transfer discards the sample.
    step(); attack = 1'b1;
    step(); attack = 1'b0;
    rnd_valid = 1'b1; rnd_data = 4'd15; new_game = 1'b1;
    check_eq("ng_xfer_ready", rdy_a, 1);
    step(); rnd_valid = 1'b0; new_game = 1'b0;
    check_eq("ng_xfer_cnt", cnt_a, 0);
    check_eq("ng_xfer_state", st_a, ST_IDLE);
    step();
    check_eq("ng_xfer_hp", hp_a, 9);
    check_eq("ng_xfer_miss", miss_a, 0);

    // Reset during WAIT_RND with a sample on offer.
    draw(4'd3);
    check_eq("pre_rst_cnt", cnt_a, 1);
    step(); attack = 1'b1;
    step(); attack = 1'b0;
    rnd_valid = 1'b1; rnd_data = 4'd15;
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_ready", rdy_a, 0);
    check_eq("midrst_cnt", cnt_a, 0);
    check_eq("midrst_miss", miss_a, 0);
    check_eq("midrst_state", st_a, ST_IDLE);
    step(); rnd_valid = 1'b0; reset = 1'b1;
    step();
    check_eq("postrst_cnt", cnt_a, 0);
    check_eq("postrst_hp", hp_a, 9);

    // DAMAGE=4 instance: 10 -> 6 -> 2 -> 0, never wrapping.
    start_new_game();
    check_eq("b_init", hp_b, 10);
    draw(4'd15);
    check_eq("b_hp1", hp_b, 6);
    draw(4'd15);
    check_eq("b_hp2", hp_b, 2);
    draw(4'd15);
    check_eq("b_hp_sat", hp_b, 0);
    check_eq("b_go", go_b, 1);
    check_eq("a_hp_same_stim", hp_a, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
